serial_reg_loader: RTL and testbench



---
 rtl/serial_reg_loader.sv | 125 ++++++++++++
 tb/tb_serial_reg_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_reg_loader.sv
// Serial command front end: synchronizes a 3-wire serial frame into clk and issues one register-write strobe per valid frame.
// Optional build macro SERIAL_PARITY_EN adds a trailing odd-parity bit to each frame.
module serial_reg_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic       sdata_in,
  input  logic       cs_n_in,
  output logic       write_strobe,
  output logic [2:0] address,
  output logic [4:0] data,
  output logic       busy,
  output logic       frame_err
);

`ifdef SERIAL_PARITY_EN
  localparam int FrameBits = 9;
`else
  localparam int FrameBits = 8;
`endif

  localparam logic [3:0] CountFull = 4'(FrameBits);
  localparam logic [3:0] CountSat  = 4'(FrameBits + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ISSUE} state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sclkSync;
  logic [SYNC_STAGES-1:0] sdataSync;
  logic [SYNC_STAGES-1:0] csSync;
  logic                 sclkDly;
  logic                 sdataDly;
  logic                 csDly;
  logic                 sclkRise;
  logic                 csRise;
  logic [3:0]           bitCount;
  logic [FrameBits-1:0] shiftReg;
  logic                 parityOk;
  logic [7:0]           payload;

  // Edge pulses are registered so sdataDly lines up with sclkRise, giving the
  // fixed SYNC_STAGES+1 latency from pin to shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclkSync  <= '0;
      sdataSync <= '0;
      csSync    <= '1;
      sclkDly   <= 1'b0;
      sdataDly  <= 1'b0;
      csDly     <= 1'b1;
      sclkRise  <= 1'b0;
      csRise    <= 1'b0;
    end else begin
      sclkSync  <= {sclkSync[SYNC_STAGES-2:0], sclk_in};
      sdataSync <= {sdataSync[SYNC_STAGES-2:0], sdata_in};
      csSync    <= {csSync[SYNC_STAGES-2:0], cs_n_in};
      sclkDly   <= sclkSync[SYNC_STAGES-1];
      sdataDly  <= sdataSync[SYNC_STAGES-1];
      csDly     <= csSync[SYNC_STAGES-1];
      sclkRise  <= sclkSync[SYNC_STAGES-1] & ~sclkDly;
      csRise    <= csSync[SYNC_STAGES-1] & ~csDly;
    end
  end

`ifdef SERIAL_PARITY_EN
  assign parityOk = ^shiftReg;
`else
  assign parityOk = 1'b1;
`endif

  assign payload = shiftReg[FrameBits-1 -: 8];
  assign busy    = (state != IDLE);

  // Frame FSM; a cs_n rise wins over a coincident sclk rise, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bitCount     <= '0;
      shiftReg     <= '0;
      address      <= '0;
      data         <= '0;
      write_strobe <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      write_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (!csDly) begin
            state    <= SHIFT;
            bitCount <= '0;
            shiftReg <= '0;
          end
        end
        SHIFT: begin
          if (csRise) begin
            if (bitCount == CountFull && parityOk) begin
              state        <= ISSUE;
              address      <= payload[7:5];
              data         <= payload[4:0];
              write_strobe <= 1'b1;
              frame_err    <= 1'b0;
            end else begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end else if (sclkRise) begin
            shiftReg <= {shiftReg[FrameBits-2:0], sdataDly};
            if (bitCount != CountSat) begin
              bitCount <= bitCount + 4'd1;
            end
          end
        end
        ISSUE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_reg_loader.sv
// Self-checking bench for serial_reg_loader: directed vector table, hand-written corner cases and randomized frames
// checked against a frame-level reference model (honours SERIAL_PARITY_EN).
module tb_serial_reg_loader;

  localparam int S = 2;
`ifdef SERIAL_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk_in;
  logic       sdata_in;
  logic       cs_n_in;
  logic       write_strobe;
  logic [2:0] address;
  logic [4:0] data;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int fails  = 0;

  logic [2:0] expAddr;
  logic [4:0] expData;
  logic       expErr;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          expStrobes;
    logic [2:0]  expAddr;
    logic [4:0]  expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[7];

  serial_reg_loader #(.SYNC_STAGES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk_in(sclk_in),
    .sdata_in(sdata_in),
    .cs_n_in(cs_n_in),
    .write_strobe(write_strobe),
    .address(address),
    .data(data),
    .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Builds a well-formed frame from an 8-bit payload.
  function automatic logic [15:0] mkFrame(input logic [7:0] pl);
`ifdef SERIAL_PARITY_EN
    return {7'd0, pl, ~^pl};
`else
    return {8'd0, pl};
`endif
  endfunction

  task automatic sendBit(input logic b);
    sdata_in = b;
    waitCycles(2);
    sclk_in = 1'b1;
    waitCycles(4);
    sclk_in = 1'b0;
    waitCycles(2);
  endtask

  task automatic startFrame(input logic [15:0] bits, input int n);
    cs_n_in = 1'b0;
    waitCycles(4);
    for (int i = n - 1; i >= 0; i--) sendBit(bits[i]);
  endtask

  // j counts clk edges from edge k (first edge sampling cs_n high), sampled on the negedge after.
  task automatic watch(output int strobes, output int firstIdx, output int busyIdx);
    strobes  = 0;
    firstIdx = -1;
    busyIdx  = -1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (write_strobe === 1'b1) begin
        if (strobes == 0) firstIdx = j;
        strobes++;
      end
      if (busy === 1'b0 && busyIdx < 0) busyIdx = j;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] bits, input int n,
                               output int strobes, output int firstIdx, output int busyIdx);
    startFrame(bits, n);
    cs_n_in = 1'b1;
    watch(strobes, firstIdx, busyIdx);
  endtask

  task automatic checkFrame(input string tag, input int strobes, input int firstIdx, input int busyIdx,
                            input int eStrobes, input logic [2:0] eAddr, input logic [4:0] eData, input logic eErr);
    checkOutput({tag, " strobes"}, strobes, eStrobes);
    if (eStrobes == 1) checkOutput({tag, " strobe cycle"}, firstIdx, S + 1);
    checkOutput({tag, " busy release"}, busyIdx, (eStrobes == 1) ? S + 2 : S + 1);
    checkOutput({tag, " address"}, address, eAddr);
    checkOutput({tag, " data"}, data, eData);
    checkOutput({tag, " frame_err"}, frame_err, eErr);
  endtask

  // Frame-level model: a frame is good when it has exactly FB bits and odd parity holds.
  task automatic modelFrame(input logic [15:0] bits, input int n, output int eStrobes);
    logic [7:0] pl;
    logic       ok;
`ifdef SERIAL_PARITY_EN
    pl = bits[8:1];
    ok = (n == FB) && ((^bits[8:0]) == 1'b1);
`else
    pl = bits[7:0];
    ok = (n == FB);
`endif
    if (ok) begin
      expAddr  = pl[7:5];
      expData  = pl[4:0];
      expErr   = 1'b0;
      eStrobes = 1;
    end else begin
      expErr   = 1'b1;
      eStrobes = 0;
    end
  endtask

  initial begin
    int strobes, firstIdx, busyIdx, eStrobes, n;
    logic [15:0] bits;

`ifdef SERIAL_PARITY_EN
    vecs[0] = '{16'h0094, 9,  1, 3'd2, 5'h0A, 1'b0};
    vecs[1] = '{16'h0095, 9,  0, 3'd2, 5'h0A, 1'b1};
    vecs[2] = '{16'h0147, 9,  1, 3'd5, 5'h03, 1'b0};
    vecs[3] = '{16'h004A, 8,  0, 3'd5, 5'h03, 1'b1};
    vecs[4] = '{16'h01FF, 9,  1, 3'd7, 5'h1F, 1'b0};
    vecs[5] = '{16'h03FF, 10, 0, 3'd7, 5'h1F, 1'b1};
    vecs[6] = '{16'h0000, 0,  0, 3'd7, 5'h1F, 1'b1};
`else
    vecs[0] = '{16'h004A, 8,  1, 3'd2, 5'h0A, 1'b0};
    vecs[1] = '{16'h0025, 7,  0, 3'd2, 5'h0A, 1'b1};
    vecs[2] = '{16'h00A3, 8,  1, 3'd5, 5'h03, 1'b0};
    vecs[3] = '{16'h03FF, 10, 0, 3'd5, 5'h03, 1'b1};
    vecs[4] = '{16'h0000, 0,  0, 3'd5, 5'h03, 1'b1};
    vecs[5] = '{16'h00FF, 8,  1, 3'd7, 5'h1F, 1'b0};
    vecs[6] = '{16'h01FF, 9,  0, 3'd7, 5'h1F, 1'b1};
`endif

    rst_n    = 1'b0;
    sclk_in  = 1'b0;
    sdata_in = 1'b0;
    cs_n_in  = 1'b1;
    waitCycles(3);
    checkOutput("reset write_strobe", write_strobe, 0);
    checkOutput("reset address", address, 0);
    checkOutput("reset data", data, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_err", frame_err, 0);
    rst_n = 1'b1;
    waitCycles(S + 3);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].bits, vecs[i].nbits, strobes, firstIdx, busyIdx);
      checkFrame($sformatf("vec%0d", i), strobes, firstIdx, busyIdx,
                 vecs[i].expStrobes, vecs[i].expAddr, vecs[i].expData, vecs[i].expErr);
    end

    // Reset mid-frame: partial frame discarded, next frame loads normally.
    cs_n_in = 1'b0;
    waitCycles(4);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    checkOutput("midreset busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset write_strobe", write_strobe, 0);
    checkOutput("midreset address", address, 0);
    checkOutput("midreset data", data, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset frame_err", frame_err, 0);
    cs_n_in = 1'b1;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(S + 3);
    applyStimulus(mkFrame(8'hFF), FB, strobes, firstIdx, busyIdx);
    checkFrame("after reset", strobes, firstIdx, busyIdx, 1, 3'd7, 5'h1F, 1'b0);

    // Coincident sclk and cs_n rise after a full frame: the extra edge is dropped.
    bits = mkFrame(8'h6D);
    startFrame(bits, FB);
    sdata_in = 1'b1;
    waitCycles(2);
    sclk_in = 1'b1;
    cs_n_in = 1'b1;
    watch(strobes, firstIdx, busyIdx);
    sclk_in = 1'b0;
    checkFrame("coincident", strobes, firstIdx, busyIdx, 1, 3'd3, 5'h0D, 1'b0);
    waitCycles(S + 3);

    expAddr = 3'd3;
    expData = 5'h0D;
    expErr  = 1'b0;
    for (int f = 0; f < 25; f++) begin
      n = ($urandom_range(0, 2) != 0) ? FB : int'($urandom_range(5, FB + 3));
      bits = ($urandom_range(0, 1) != 0) ? mkFrame(8'($urandom)) : 16'($urandom);
      modelFrame(bits, n, eStrobes);
      applyStimulus(bits, n, strobes, firstIdx, busyIdx);
      checkFrame($sformatf("rand%0d n=%0d bits=%0h", f, n, bits), strobes, firstIdx, busyIdx,
                 eStrobes, expAddr, expData, expErr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
